// File: rtl/fetch_pc_unit.sv
// PC register and instruction fetch: REQ -> VALID takes one cycle with zero wait states.
// Memory backpressure holds REQ (address stable); decode stall holds VALID (instr/pc stable).
module fetch_pc_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] offset,
    input  logic       branch_taken,
    input  logic       halt_req,
    input  logic       stall,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ready,
    input  logic [7:0] imem_data,
    output logic [7:0] instr,
    output logic       instr_valid,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pc_q;
    logic [7:0] pc_nxt;
    logic [7:0] instr_q;
    logic [7:0] instr_nxt;
    logic       valid_q;
    logic       valid_nxt;
    logic       halted_q;
    logic       halted_nxt;
    logic [7:0] pc_seq;
    logic [7:0] branch_target;

    // Branch target is relative to the following instruction; wraps modulo 256.
    assign pc_seq        = pc_q + 8'd1;
    assign branch_target = pc_seq + offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc_q     <= 8'h00;
            instr_q  <= 8'h00;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            valid_q  <= valid_nxt;
            halted_q <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        instr_nxt  = instr_q;
        valid_nxt  = valid_q;
        halted_nxt = halted_q;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    instr_nxt = imem_data;
                    valid_nxt = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    valid_nxt = 1'b0;
                    // Halt wins over a simultaneous branch verdict.
                    if (halt_req) begin
                        halted_nxt = 1'b1;
                        state_nxt  = HALT;
                    end else begin
                        pc_nxt    = branch_taken ? branch_target : pc_seq;
                        state_nxt = REQ;
                    end
                end
            end
            HALT: begin
                valid_nxt  = 1'b0;
                halted_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request is decoded from state so an asynchronous reset drops it at once.
    assign imem_req    = (state == REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: stimulus pushes expected fetch addresses and
// presented instructions into queues; a negedge monitor pops and compares them.
module tb_fetch_pc_unit;

    logic       clk;
    logic       reset;
    logic [7:0] offset;
    logic       branch_taken;
    logic       halt_req;
    logic       stall;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic [7:0] pc;
    logic       halted;

    int total = 0;
    int bad   = 0;

    logic [7:0]  addr_q[$];
    logic [15:0] vld_q[$];
    logic        prev_req;
    logic        prev_vld;
    logic [7:0]  cur_pc;
    logic [7:0]  cur_instr;
    int          n;

    fetch_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .offset       (offset),
        .branch_taken (branch_taken),
        .halt_req     (halt_req),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a rising imem_req is a new fetch; a rising instr_valid is a new presentation.
    always @(negedge clk) begin
        if (reset) begin
            prev_req <= 1'b0;
            prev_vld <= 1'b0;
        end else begin
            if (imem_req && !prev_req) begin
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req actual=%0h required=none", imem_addr);
                end else begin
                    chk("req_addr", {24'h0, imem_addr}, {24'h0, addr_q.pop_front()});
                end
            end
            if (instr_valid && !prev_vld) begin
                if (vld_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=%0h required=none", instr);
                end else begin
                    chk("instr_pc", {16'h0, instr, pc}, {16'h0, vld_q.pop_front()});
                end
            end
            prev_req <= imem_req;
            prev_vld <= instr_valid;
        end
    end

    task automatic do_fetch(input logic [7:0] a, input logic [7:0] d, input int waits,
                            output int edges);
        addr_q.push_back(a);
        vld_q.push_back({d, a});
        edges = 0;
        while (!imem_req && edges < 20) begin
            @(posedge clk);
            #2;
            edges++;
        end
        if (!imem_req) begin
            total++;
            bad++;
            $display("FAIL req_timeout actual=0 required=1");
        end
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_data  = 8'hEE;
            @(posedge clk);
            #2;
            chk("wait_hold", {22'h0, imem_req, instr_valid, imem_addr}, {22'h0, 1'b1, 1'b0, a});
        end
        imem_ready = 1'b1;
        imem_data  = d;
        @(posedge clk);
        #2;
        imem_ready = 1'b0;
        imem_data  = 8'h00;
        cur_pc     = a;
        cur_instr  = d;
    endtask

    task automatic consume(input logic br, input logic [7:0] off, input logic hlt,
                           input int stalls, input logic [7:0] next_pc);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            @(posedge clk);
            #2;
            chk("stall_hold", {15'h0, instr_valid, imem_req, instr, pc},
                {15'h0, 1'b1, 1'b0, cur_instr, cur_pc});
        end
        stall        = 1'b0;
        branch_taken = br;
        offset       = off;
        halt_req     = hlt;
        @(posedge clk);
        #2;
        stall        = 1'b1;
        branch_taken = 1'b0;
        offset       = 8'h00;
        if (hlt) begin
            chk("halt_state", {21'h0, halted, instr_valid, imem_req, pc},
                {21'h0, 1'b1, 1'b0, 1'b0, cur_pc});
        end else begin
            halt_req = 1'b0;
            chk("next_addr", {22'h0, imem_req, instr_valid, imem_addr},
                {22'h0, 1'b1, 1'b0, next_pc});
        end
    endtask

    typedef struct packed {
        logic [7:0] at;
        logic [7:0] off;
        logic       br;
        logic [7:0] nxt;
    } br_vec_t;

    br_vec_t br_tab[8];

    initial begin
        br_tab[0] = '{at: 8'h10, off: 8'h00, br: 1'b1, nxt: 8'h11};
        br_tab[1] = '{at: 8'h11, off: 8'hFE, br: 1'b1, nxt: 8'h10};
        br_tab[2] = '{at: 8'h10, off: 8'h01, br: 1'b1, nxt: 8'h12};
        br_tab[3] = '{at: 8'h12, off: 8'hFE, br: 1'b1, nxt: 8'h11};
        br_tab[4] = '{at: 8'h11, off: 8'hFE, br: 1'b1, nxt: 8'h10};
        br_tab[5] = '{at: 8'h10, off: 8'hFF, br: 1'b1, nxt: 8'h10};
        br_tab[6] = '{at: 8'h10, off: 8'hFE, br: 1'b1, nxt: 8'h0F};
        br_tab[7] = '{at: 8'h0F, off: 8'h01, br: 1'b0, nxt: 8'h10};

        reset        = 1'b1;
        stall        = 1'b1;
        branch_taken = 1'b0;
        halt_req     = 1'b0;
        offset       = 8'h00;
        imem_ready   = 1'b0;
        imem_data    = 8'h00;
        cur_pc       = 8'h00;
        cur_instr    = 8'h00;

        repeat (3) begin
            @(posedge clk);
            #2;
            chk("reset_outs", {3'h0, imem_req, instr_valid, halted, pc, instr, imem_addr}, 32'h0);
        end
        reset = 1'b0;

        do_fetch(8'h00, 8'h12, 0, n);
        chk("boot_latency", n, 1);
        consume(1'b0, 8'h00, 1'b0, 0, 8'h01);

        for (int a = 1; a < 4; a++) begin
            do_fetch(8'(a), 8'(a) ^ 8'h5A, 0, n);
            consume(1'b0, 8'hFF, 1'b0, 0, 8'(a + 1));
        end
        do_fetch(8'h04, 8'h3C, 0, n);
        consume(1'b0, 8'h00, 1'b0, 3, 8'h05);

        for (int a = 5; a < 16; a++) begin
            do_fetch(8'(a), 8'(a) ^ 8'h5A, 0, n);
            consume(1'b0, 8'h00, 1'b0, 0, 8'(a + 1));
        end

        for (int i = 0; i < 8; i++) begin
            do_fetch(br_tab[i].at, 8'hB0 + 8'(i), 0, n);
            consume(br_tab[i].br, br_tab[i].off, 1'b0, 0, br_tab[i].nxt);
        end

        do_fetch(8'h10, 8'hC7, 4, n);
        consume(1'b0, 8'h00, 1'b0, 1, 8'h11);

        // Reset while the fetch of 0x11 is outstanding.
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", {7'h0, imem_req, instr_valid, halted, pc, instr, imem_addr}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;

        do_fetch(8'h00, 8'h21, 0, n);
        chk("reboot_latency", n, 1);
        consume(1'b1, 8'hFE, 1'b0, 0, 8'hFF);
        do_fetch(8'hFF, 8'h44, 0, n);
        consume(1'b0, 8'h00, 1'b0, 0, 8'h00);

        for (int a = 0; a < 32; a++) begin
            do_fetch(8'(a), 8'(a) ^ 8'hA5, 0, n);
            consume(1'b0, 8'h00, 1'b0, 0, 8'(a + 1));
        end
        do_fetch(8'h20, 8'h7E, 0, n);
        consume(1'b1, 8'h01, 1'b1, 0, 8'h00);

        imem_ready   = 1'b1;
        imem_data    = 8'h99;
        stall        = 1'b0;
        branch_taken = 1'b1;
        offset       = 8'h01;
        repeat (6) begin
            @(posedge clk);
            #2;
            chk("halt_hold", {21'h0, halted, instr_valid, imem_req, pc},
                {21'h0, 1'b1, 1'b0, 1'b0, 8'h20});
        end

        #20;
        chk("addr_q_empty", addr_q.size(), 0);
        chk("vld_q_empty", vld_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
